// File: rtl/decode_stage.sv
// Decode stage: field extraction, immediate generation, pending-write scoreboard and output register.
// Optional macro DECODE_BYPASS_EN forwards a same-cycle writeback into the operands and hazard check.
module decode_stage #(
  parameter int ARCH_LEN     = 32,
  parameter int REG_FILE_LEN = 32,
  localparam int RW          = $clog2(REG_FILE_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ARCH_LEN-1:0] in_pc,
  input  logic [ARCH_LEN-1:0] in_instr,
  output logic [RW-1:0]       src_reg_1,
  output logic [RW-1:0]       src_reg_2,
  input  logic [ARCH_LEN-1:0] src_data_1,
  input  logic [ARCH_LEN-1:0] src_data_2,
  input  logic                wb_valid,
  input  logic [RW-1:0]       wb_dst_reg,
  input  logic [ARCH_LEN-1:0] wb_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ARCH_LEN-1:0] out_pc,
  output logic [ARCH_LEN-1:0] out_rs1_data,
  output logic [ARCH_LEN-1:0] out_rs2_data,
  output logic [ARCH_LEN-1:0] out_imm,
  output logic [RW-1:0]       out_rd,
  output logic [6:0]          out_opcode,
  output logic [2:0]          out_funct3,
  output logic [6:0]          out_funct7,
  output logic                out_writes_rd
);

  function automatic logic [ARCH_LEN-1:0] gen_imm(input logic [31:0] ins);
    logic [31:0] imm;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: imm = {{20{ins[31]}}, ins[31:20]};
      7'b0100011: imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      7'b1100011: imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      7'b0110111, 7'b0010111: imm = {ins[31:12], 12'h000};
      7'b1101111: imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return ARCH_LEN'($signed(imm));
  endfunction

  function automatic logic gen_writes_rd(input logic [6:0] opcode, input logic [4:0] rd);
    logic wr;
    case (opcode)
      7'b0100011, 7'b1100011: wr = 1'b0;
      default: wr = (rd != 5'd0);
    endcase
    return wr;
  endfunction

  logic [REG_FILE_LEN-1:0] pending;
  logic [REG_FILE_LEN-1:0] pending_nxt;
  logic [RW-1:0]           dec_rd;
  logic                    dec_writes_rd;
  logic [ARCH_LEN-1:0]     dec_imm;
  logic                    rs1_busy;
  logic                    rs2_busy;
  logic                    hazard;
  logic                    accept;
  logic [ARCH_LEN-1:0]     rs1_data;
  logic [ARCH_LEN-1:0]     rs2_data;

  assign src_reg_1     = RW'(in_instr[19:15]);
  assign src_reg_2     = RW'(in_instr[24:20]);
  assign dec_rd        = RW'(in_instr[11:7]);
  assign dec_writes_rd = gen_writes_rd(in_instr[6:0], in_instr[11:7]);
  assign dec_imm       = gen_imm(in_instr[31:0]);

`ifdef DECODE_BYPASS_EN
  // A writeback landing this cycle resolves the source hazard and supplies the operand directly.
  assign rs1_busy = pending[src_reg_1] && !(wb_valid && (wb_dst_reg == src_reg_1));
  assign rs2_busy = pending[src_reg_2] && !(wb_valid && (wb_dst_reg == src_reg_2));
  assign rs1_data = (src_reg_1 == {RW{1'b0}}) ? {ARCH_LEN{1'b0}} :
                    (wb_valid && (wb_dst_reg == src_reg_1)) ? wb_data : src_data_1;
  assign rs2_data = (src_reg_2 == {RW{1'b0}}) ? {ARCH_LEN{1'b0}} :
                    (wb_valid && (wb_dst_reg == src_reg_2)) ? wb_data : src_data_2;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign rs1_busy = pending[src_reg_1];
  assign rs2_busy = pending[src_reg_2];
  assign rs1_data = (src_reg_1 == {RW{1'b0}}) ? {ARCH_LEN{1'b0}} : src_data_1;
  assign rs2_data = (src_reg_2 == {RW{1'b0}}) ? {ARCH_LEN{1'b0}} : src_data_2;
`endif

  assign hazard   = in_valid && (rs1_busy || rs2_busy || pending[dec_rd]);
  assign in_ready = rst && !hazard && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Scoreboard next state: a new claim beats any clear; register 0 never pends.
  always_comb begin
    pending_nxt = {REG_FILE_LEN{1'b0}};
    for (int i = 1; i < REG_FILE_LEN; i++) begin
      pending_nxt[i] = (accept && dec_writes_rd && (dec_rd == RW'(i))) ||
                       (pending[i] &&
                        !(wb_valid && (wb_dst_reg == RW'(i))) &&
                        !(flush && out_valid && out_writes_rd && (out_rd == RW'(i))));
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= {REG_FILE_LEN{1'b0}};
    end else begin
      pending <= pending_nxt;
    end
  end

  // Output register: load on accept, drop on consume or flush, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      out_pc        <= {ARCH_LEN{1'b0}};
      out_rs1_data  <= {ARCH_LEN{1'b0}};
      out_rs2_data  <= {ARCH_LEN{1'b0}};
      out_imm       <= {ARCH_LEN{1'b0}};
      out_rd        <= {RW{1'b0}};
      out_opcode    <= 7'd0;
      out_funct3    <= 3'd0;
      out_funct7    <= 7'd0;
      out_writes_rd <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_rs1_data  <= rs1_data;
      out_rs2_data  <= rs2_data;
      out_imm       <= dec_imm;
      out_rd        <= dec_rd;
      out_opcode    <= in_instr[6:0];
      out_funct3    <= in_instr[14:12];
      out_funct7    <= in_instr[31:25];
      out_writes_rd <= dec_writes_rd;
    end else if (flush || out_ready) begin
      out_valid     <= 1'b0;
    end else begin
      out_valid     <= out_valid;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; expectations are hand-decoded RV32 encodings.
// Honors DECODE_BYPASS_EN for the writeback-bypass scenario.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic [4:0]  src_reg_1;
  logic [4:0]  src_reg_2;
  logic [31:0] src_data_1;
  logic [31:0] src_data_2;
  logic        wb_valid;
  logic [4:0]  wb_dst_reg;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_rs1_data;
  logic [31:0] out_rs2_data;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic        out_writes_rd;

  int vectors    = 0;
  int miscompares = 0;

`ifdef DECODE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  decode_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .src_reg_1(src_reg_1), .src_reg_2(src_reg_2),
    .src_data_1(src_data_1), .src_data_2(src_data_2),
    .wb_valid(wb_valid), .wb_dst_reg(wb_dst_reg), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_imm(out_imm), .out_rd(out_rd), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_writes_rd(out_writes_rd)
  );

  always #5 clk = ~clk;

  // Fixed register-file contents; x0 reads garbage so the zeroing of rs = 0 is visible.
  always_comb begin
    src_data_1 = (src_reg_1 == 5'd0) ? 32'hDEAD_BEEF : (32'h1000_0000 | {27'd0, src_reg_1});
    src_data_2 = (src_reg_2 == 5'd0) ? 32'hDEAD_BEEF : (32'h1000_0000 | {27'd0, src_reg_2});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_pc = 32'h0000_0100; in_instr = 32'h0050_0093;
    wb_valid = 1'b0; wb_dst_reg = 5'd0; wb_data = 32'd0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_pc !== 32'd0) begin miscompares++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    vectors++; if (out_imm !== 32'd0 || out_rd !== 5'd0) begin miscompares++; $display("FAIL reset_out_data: got imm %h rd %0d want 0 0", out_imm, out_rd); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0; rst = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    in_valid = 1'b1; in_pc = 32'h0000_0100; in_instr = 32'h0050_0093;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL addi_in_ready: got %b want 1", in_ready); end
    vectors++; if (src_reg_1 !== 5'd0 || src_reg_2 !== 5'd5) begin miscompares++; $display("FAIL addi_src_regs: got %0d %0d want 0 5", src_reg_1, src_reg_2); end
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL addi_out_valid: got %b want 1", out_valid); end
    vectors++; if (out_rd !== 5'd1 || out_imm !== 32'd5) begin miscompares++; $display("FAIL addi_rd_imm: got rd %0d imm %h want 1 5", out_rd, out_imm); end
    vectors++; if (out_opcode !== 7'h13 || out_writes_rd !== 1'b1 || out_pc !== 32'h100) begin miscompares++; $display("FAIL addi_fields: got op %h wr %b pc %h want 13 1 100", out_opcode, out_writes_rd, out_pc); end
    vectors++; if (out_rs1_data !== 32'd0 || out_rs2_data !== 32'h1000_0005) begin miscompares++; $display("FAIL addi_operands: got %h %h want 0 10000005", out_rs1_data, out_rs2_data); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL addi_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_raw();
    in_valid = 1'b1; in_pc = 32'h0000_0104; in_instr = 32'h0010_8133;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL raw_stall: got %b want 0", in_ready); end
    tick();
    vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL raw_stall_hold: got rdy %b vld %b want 0 0", in_ready, out_valid); end
    wb_valid = 1'b1; wb_dst_reg = 5'd1; wb_data = 32'hCAFE_0001;
    #1;
    vectors++; if (in_ready !== BYP) begin miscompares++; $display("FAIL raw_wb_cycle_ready: got %b want %b", in_ready, BYP); end
    tick();
    wb_valid = 1'b0;
    if (BYP) begin
      vectors++; if (out_valid !== 1'b1 || out_rd !== 5'd2) begin miscompares++; $display("FAIL raw_bypass_accept: got vld %b rd %0d want 1 2", out_valid, out_rd); end
      vectors++; if (out_rs1_data !== 32'hCAFE_0001 || out_rs2_data !== 32'hCAFE_0001) begin miscompares++; $display("FAIL raw_bypass_data: got %h %h want cafe0001", out_rs1_data, out_rs2_data); end
    end else begin
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL raw_extra_stall: got %b want 0", out_valid); end
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL raw_late_ready: got %b want 1", in_ready); end
      tick();
      vectors++; if (out_valid !== 1'b1 || out_rd !== 5'd2) begin miscompares++; $display("FAIL raw_late_accept: got vld %b rd %0d want 1 2", out_valid, out_rd); end
      vectors++; if (out_rs1_data !== 32'h1000_0001) begin miscompares++; $display("FAIL raw_late_data: got %h want 10000001", out_rs1_data); end
    end
    in_valid = 1'b0; wb_valid = 1'b1; wb_dst_reg = 5'd2;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_branch();
    in_valid = 1'b1; in_pc = 32'h0000_0200; in_instr = 32'hFE00_0CE3;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL beq_ready: got %b want 1", in_ready); end
    tick();
    vectors++; if (out_imm !== 32'hFFFF_FFF8 || out_writes_rd !== 1'b0) begin miscompares++; $display("FAIL beq_decode: got imm %h wr %b want fffffff8 0", out_imm, out_writes_rd); end
    // addi x4,x25,-1 right behind: x25 (the beq rd field) must not have been claimed.
    in_pc = 32'h0000_0204; in_instr = 32'hFFFC_8213;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL beq_no_pending: got %b want 1", in_ready); end
    tick();
    vectors++; if (out_valid !== 1'b1 || out_imm !== 32'hFFFF_FFFF || out_rs1_data !== 32'h1000_0019) begin miscompares++; $display("FAIL b2b_addi: got vld %b imm %h rs1 %h want 1 ffffffff 10000019", out_valid, out_imm, out_rs1_data); end
    in_valid = 1'b0; wb_valid = 1'b1; wb_dst_reg = 5'd4;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_imm_formats();
    logic [31:0] instrs [7] = '{32'h1234_5037, 32'hFFFF_F017, 32'hFFDF_F06F, 32'hFE20_AA23,
                                32'h7FF0_0067, 32'h0000_0033, 32'hFFFF_F07F};
    logic [31:0] imms   [7] = '{32'h1234_5000, 32'hFFFF_F000, 32'hFFFF_FFFC, 32'hFFFF_FFF4,
                                32'h0000_07FF, 32'h0000_0000, 32'h0000_0000};
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_pc = 32'h0000_0600 + 32'(4 * i); in_instr = instrs[i];
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL imm_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
      vectors++; if (out_valid !== 1'b1 || out_imm !== imms[i] || out_writes_rd !== 1'b0) begin miscompares++; $display("FAIL imm_decode[%0d]: got vld %b imm %h wr %b want 1 %h 0", i, out_valid, out_imm, out_writes_rd, imms[i]); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h0000_0300; in_instr = 32'h0070_0313;
    tick();
    in_pc = 32'h0000_0304; in_instr = 32'h0090_0393;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready[%0d]: got %b want 0", c, in_ready); end
      tick();
      vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h300 || out_imm !== 32'd7 || out_rd !== 5'd6) begin miscompares++; $display("FAIL stall_hold[%0d]: got vld %b pc %h imm %h rd %0d want 1 300 7 6", c, out_valid, out_pc, out_imm, out_rd); end
    end
    out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    tick();
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h304 || out_imm !== 32'd9) begin miscompares++; $display("FAIL stall_release: got vld %b pc %h imm %h want 1 304 9", out_valid, out_pc, out_imm); end
    // addi x6,x0,1 while x6 is still claimed: write-after-write must stall.
    in_instr = 32'h0010_0313;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL waw_stall: got %b want 0", in_ready); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h0000_0400; in_instr = 32'h0030_0193;
    tick();
    vectors++; if (out_valid !== 1'b1 || out_rd !== 5'd3) begin miscompares++; $display("FAIL flush_setup: got vld %b rd %0d want 1 3", out_valid, out_rd); end
    flush = 1'b1; in_pc = 32'h0000_0404; in_instr = 32'h0001_8433;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_blocks_accept: got %b want 0", in_ready); end
    tick();
    flush = 1'b0; out_ready = 1'b1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_pending_cleared: got %b want 1", in_ready); end
    tick();
    vectors++; if (out_valid !== 1'b1 || out_rd !== 5'd8 || out_pc !== 32'h404 || out_rs1_data !== 32'h1000_0003) begin miscompares++; $display("FAIL flush_next: got vld %b rd %0d pc %h rs1 %h want 1 8 404 10000003", out_valid, out_rd, out_pc, out_rs1_data); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h0000_0500; in_instr = 32'h0010_0293;
    tick();
    vectors++; if (out_valid !== 1'b1 || out_rd !== 5'd5) begin miscompares++; $display("FAIL rstmid_setup: got vld %b rd %0d want 1 5", out_valid, out_rd); end
    rst = 1'b0; in_pc = 32'h0000_0504; in_instr = 32'h0002_8493;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready_low: got %b want 0", in_ready); end
    tick();
    vectors++; if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_rd !== 5'd0 || out_imm !== 32'd0) begin miscompares++; $display("FAIL rstmid_cleared: got vld %b pc %h rd %0d imm %h want 0 0 0 0", out_valid, out_pc, out_rd, out_imm); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready_hold: got %b want 0", in_ready); end
    tick();
    rst = 1'b1; out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_pending_cleared: got %b want 1", in_ready); end
    tick();
    vectors++; if (out_valid !== 1'b1 || out_rd !== 5'd9 || out_rs1_data !== 32'h1000_0005) begin miscompares++; $display("FAIL rstmid_resume: got vld %b rd %0d rs1 %h want 1 9 10000005", out_valid, out_rd, out_rs1_data); end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_raw();
    test_branch();
    test_imm_formats();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
